// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port byte memory.
// A requester owns the memory for as long as it holds its req line; between
// owners a 2-cycle DRAIN lets in-flight reads of the departing owner return.
// Reads are tracked by a 2-stage {valid, owner} tag pipeline: memory output
// is registered once in the memory and once more here (rdata), giving
// rvalid exactly 2 cycles after the granted read cycle.
// Optional feature macro: ARB_ROUNDROBIN_EN (round-robin tie break); when it
// is undefined requester 0 always wins a tie.
//
// Handshake: reqN is held high for the whole burst; while gntN is high each
// cycle in which reqN is still high is one access (weN=1 write, weN=0 read).
// The cycle in which a requester drops reqN it is no longer issuing, so that
// cycle produces neither a write nor a read even though gntN is still high.
module mem_arbiter #(
    parameter int addr_width = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    output logic                  gnt0,
    output logic                  gnt1,
    input  logic [addr_width-1:0] addr0,
    input  logic [addr_width-1:0] addr1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [7:0]            wdata0,
    input  logic [7:0]            wdata1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [7:0]            rdata,
    output logic [addr_width-1:0] mem_raddr,
    output logic [addr_width-1:0] mem_waddr,
    output logic [7:0]            mem_data_in,
    output logic                  mem_write,
    input  logic [7:0]            mem_data_out,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [1:0]            r_drain_cnt;
    logic                  w_tie_pick1;
    logic                  w_rd0;
    logic                  w_rd1;
    logic                  w_wr0;
    logic                  w_wr1;
    logic [addr_width-1:0] w_addr;
    logic [7:0]            w_wdata;
    logic [addr_width-1:0] r_hold_addr;
    logic [7:0]            r_hold_wdata;
    logic                  r_tag1_valid;
    logic                  r_tag1_owner;
    logic                  r_tag2_valid;
    logic                  r_tag2_owner;
    logic [7:0]            r_rdata;

`ifdef ARB_ROUNDROBIN_EN
    logic r_last_owner;

    // Remember which requester was granted last; reset value 1 makes
    // requester 0 win the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_owner <= 1'b1;
        end else if (r_state == ST_IDLE && w_next == ST_OWN0) begin
            r_last_owner <= 1'b0;
        end else if (r_state == ST_IDLE && w_next == ST_OWN1) begin
            r_last_owner <= 1'b1;
        end
    end

    assign w_tie_pick1 = ~r_last_owner;
`else
    assign w_tie_pick1 = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; ownership only ends when the owner drops req.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req0 && req1) begin
                    w_next = w_tie_pick1 ? ST_OWN1 : ST_OWN0;
                end else if (req0) begin
                    w_next = ST_OWN0;
                end else if (req1) begin
                    w_next = ST_OWN1;
                end
            end
            ST_OWN0:  if (!req0) w_next = ST_DRAIN;
            ST_OWN1:  if (!req1) w_next = ST_DRAIN;
            ST_DRAIN: if (r_drain_cnt == 2'd1) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // DRAIN cycle counter: 0 on the first DRAIN cycle, 1 on the second.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drain_cnt <= 2'd0;
        end else if (r_state != ST_DRAIN) begin
            r_drain_cnt <= 2'd0;
        end else begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
        end
    end

    assign gnt0        = (r_state == ST_OWN0);
    assign gnt1        = (r_state == ST_OWN1);
    assign o_dbg_state = r_state;

    assign w_rd0 = gnt0 & req0 & ~we0;
    assign w_rd1 = gnt1 & req1 & ~we1;
    assign w_wr0 = gnt0 & req0 & we0;
    assign w_wr1 = gnt1 & req1 & we1;

    assign w_addr  = gnt0 ? addr0  : (gnt1 ? addr1  : r_hold_addr);
    assign w_wdata = gnt0 ? wdata0 : (gnt1 ? wdata1 : r_hold_wdata);

    assign mem_raddr   = w_addr;
    assign mem_waddr   = w_addr;
    assign mem_data_in = w_wdata;
    assign mem_write   = w_wr0 | w_wr1;

    // Keep the last driven address/data so they hold while nobody owns memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold_addr  <= '0;
            r_hold_wdata <= 8'd0;
        end else begin
            r_hold_addr  <= w_addr;
            r_hold_wdata <= w_wdata;
        end
    end

    // Read tag pipeline and registered read data, aligned to the memory latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tag1_valid <= 1'b0;
            r_tag1_owner <= 1'b0;
            r_tag2_valid <= 1'b0;
            r_tag2_owner <= 1'b0;
            r_rdata      <= 8'd0;
        end else begin
            r_tag1_valid <= w_rd0 | w_rd1;
            r_tag1_owner <= gnt1;
            r_tag2_valid <= r_tag1_valid;
            r_tag2_owner <= r_tag1_owner;
            r_rdata      <= mem_data_out;
        end
    end

    assign rdata   = r_rdata;
    assign rvalid0 = r_tag2_valid & ~r_tag2_owner;
    assign rvalid1 = r_tag2_valid &  r_tag2_owner;

endmodule
